// File: rtl/vdg_timing_pkg.sv
// Raster timing constants and frame-format encoding shared by the VDG timing generator.
package vdg_timing_pkg;

  localparam int VDG_H_TOTAL      = 458;
  localparam int VDG_H_SYNC       = 29;
  localparam int VDG_H_ACT_START  = 96;
  localparam int VDG_H_ACT_LEN    = 256;
  localparam int VDG_V_TOTAL0     = 262;
  localparam int VDG_V_TOTAL1     = 312;
  localparam int VDG_V_SYNC       = 8;
  localparam int VDG_V_ACT_START0 = 38;
  localparam int VDG_V_ACT_START1 = 64;
  localparam int VDG_V_ACT_LEN    = 192;
  localparam int VDG_CHAR_LINES   = 12;
  localparam int VDG_PRELOAD_LEAD = 8;

  typedef enum logic {
    FMT_60 = 1'b0,
    FMT_50 = 1'b1
  } fmt_e;

endpackage

// File: rtl/video_timing_gen_counter.sv
// Modulo counter 0..MAX with enable and synchronous clear; next_o exposes the value
// the register takes on the coming edge so callers can decode it one cycle early.
module mod_counter #(
  parameter int WIDTH = 10,
  parameter int MAX   = (1 << WIDTH) - 1
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] next_o,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q, count_d;

  assign tc_o = en_i && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clr_i || tc_o) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count_o = count_q;
  assign next_o  = count_d;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator for the VDG core: syncs, blanking, counts and fetch strobes.
// Every flag is a registered decode of the next col/row, so flags and counts never skew.
module video_timing_gen
  import vdg_timing_pkg::*;
#(
  parameter int H_TOTAL      = VDG_H_TOTAL,
  parameter int H_SYNC       = VDG_H_SYNC,
  parameter int H_ACT_START  = VDG_H_ACT_START,
  parameter int H_ACT_LEN    = VDG_H_ACT_LEN,
  parameter int V_TOTAL0     = VDG_V_TOTAL0,
  parameter int V_TOTAL1     = VDG_V_TOTAL1,
  parameter int V_SYNC       = VDG_V_SYNC,
  parameter int V_ACT_START0 = VDG_V_ACT_START0,
  parameter int V_ACT_START1 = VDG_V_ACT_START1,
  parameter int V_ACT_LEN    = VDG_V_ACT_LEN,
  parameter int CHAR_LINES   = VDG_CHAR_LINES,
  parameter int PRELOAD_LEAD = VDG_PRELOAD_LEAD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       format,
  output logic       hsn,
  output logic       fsn,
  output logic       hblank,
  output logic       vblank,
  output logic       active,
  output logic [9:0] col,
  output logic [8:0] row,
  output logic [3:0] char_line,
  output logic       preload,
  output logic       rowclear
);

  localparam int V_MAX = (V_TOTAL1 > V_TOTAL0) ? V_TOTAL1 : V_TOTAL0;

  if (H_TOTAL > 1024 || V_MAX > 512 || CHAR_LINES < 1 || CHAR_LINES > 16 ||
      H_ACT_START + H_ACT_LEN > H_TOTAL || PRELOAD_LEAD > H_ACT_START ||
      V_ACT_START0 + V_ACT_LEN > V_TOTAL0 || V_ACT_START1 + V_ACT_LEN > V_TOTAL1 ||
      V_ACT_START0 < 1 || V_ACT_START1 < 1) begin : g_bad_params
    $error("video_timing_gen: timing parameters out of range");
  end

  localparam logic [9:0]  H_SYNC_C   = 10'(H_SYNC);
  localparam logic [9:0]  H_ACT_LO   = 10'(H_ACT_START);
  localparam logic [10:0] H_ACT_HI   = 11'(H_ACT_START + H_ACT_LEN);
  localparam logic [9:0]  PRE_COL    = 10'(H_ACT_START - PRELOAD_LEAD);
  localparam logic [8:0]  V_SYNC_C   = 9'(V_SYNC);
  localparam logic [8:0]  V_LAST0    = 9'(V_TOTAL0 - 1);
  localparam logic [8:0]  V_LAST1    = 9'(V_TOTAL1 - 1);
  localparam logic [8:0]  V_LAST_MAX = 9'(V_MAX - 1);
  localparam logic [8:0]  V_START0   = 9'(V_ACT_START0);
  localparam logic [8:0]  V_START1   = 9'(V_ACT_START1);
  localparam logic [9:0]  V_END0     = 10'(V_ACT_START0 + V_ACT_LEN);
  localparam logic [9:0]  V_END1     = 10'(V_ACT_START1 + V_ACT_LEN);
  localparam logic [3:0]  CL_LAST    = 4'(CHAR_LINES - 1);

  logic [9:0] col_q, col_n;
  logic [8:0] row_q, row_n, cur_last, v_start_n;
  logic [9:0] v_end_n;
  logic       col_tc, row_tc, short_wrap, frame_wrap, row_act_n;
  fmt_e       fmt_q, fmt_d;
  logic [3:0] char_q, char_d;
  logic       hsn_q, fsn_q, hblank_q, vblank_q, active_q, preload_q, rowclear_q;
  logic       hsn_d, fsn_d, hblank_d, vblank_d, active_d, preload_d, rowclear_d;

  mod_counter #(.WIDTH(10), .MAX(H_TOTAL - 1)) u_col_cnt (
    .clk    (clk),
    .en_i   (1'b1),
    .clr_i  (reset),
    .count_o(col_q),
    .next_o (col_n),
    .tc_o   (col_tc)
  );

  // The row counter spans the longer format; the shorter one wraps early via clear.
  mod_counter #(.WIDTH(9), .MAX(V_MAX - 1)) u_row_cnt (
    .clk    (clk),
    .en_i   (col_tc),
    .clr_i  (reset || short_wrap),
    .count_o(row_q),
    .next_o (row_n),
    .tc_o   (row_tc)
  );

  assign cur_last   = (fmt_q == FMT_50) ? V_LAST1 : V_LAST0;
  assign short_wrap = col_tc && (row_q == cur_last) && (cur_last != V_LAST_MAX);
  assign frame_wrap = row_tc || short_wrap;

  always_comb begin
    fmt_d      = fmt_q;
    char_d     = char_q;
    if (reset || frame_wrap) begin
      fmt_d = fmt_e'(format);
    end
    v_start_n  = (fmt_d == FMT_50) ? V_START1 : V_START0;
    v_end_n    = (fmt_d == FMT_50) ? V_END1 : V_END0;
    row_act_n  = (row_n >= v_start_n) && ({1'b0, row_n} < v_end_n);

    if (reset) begin
      char_d = '0;
    end else if (col_tc) begin
      if (!row_act_n || row_n == v_start_n || char_q == CL_LAST) begin
        char_d = '0;
      end else begin
        char_d = char_q + 4'd1;
      end
    end

    hsn_d      = col_n >= H_SYNC_C;
    fsn_d      = row_n >= V_SYNC_C;
    hblank_d   = !((col_n >= H_ACT_LO) && ({1'b0, col_n} < H_ACT_HI));
    vblank_d   = !row_act_n;
    active_d   = !hblank_d && row_act_n;
    preload_d  = (col_n == PRE_COL) && row_act_n;
    rowclear_d = (col_n == 10'd0) && (row_n == v_start_n);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fmt_q      <= fmt_e'(format);
      char_q     <= '0;
      hsn_q      <= 1'b0;
      fsn_q      <= 1'b0;
      hblank_q   <= 1'b1;
      vblank_q   <= 1'b1;
      active_q   <= 1'b0;
      preload_q  <= 1'b0;
      rowclear_q <= 1'b0;
    end else begin
      fmt_q      <= fmt_d;
      char_q     <= char_d;
      hsn_q      <= hsn_d;
      fsn_q      <= fsn_d;
      hblank_q   <= hblank_d;
      vblank_q   <= vblank_d;
      active_q   <= active_d;
      preload_q  <= preload_d;
      rowclear_q <= rowclear_d;
    end
  end

  assign hsn       = hsn_q;
  assign fsn       = fsn_q;
  assign hblank    = hblank_q;
  assign vblank    = vblank_q;
  assign active    = active_q;
  assign preload   = preload_q;
  assign rowclear  = rowclear_q;
  assign col       = col_q;
  assign row       = row_q;
  assign char_line = char_q;

endmodule
